// File: rtl/mac_requant_accum.sv
// Accumulates runs of 19-bit MAC partial sums, requantizes each finished sum to int8
// (rounding arithmetic shift + saturation) and buffers results in a small FWFT FIFO.
module mac_requant_accum #(
  parameter int ACC_W      = 32,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_valid,
  input  logic [18:0]      i_res,
  input  logic [LEN_W-1:0] i_len,
  input  logic [4:0]       i_shift,
  input  logic             i_clear,
  output logic             o_valid,
  output logic [7:0]       o_data,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_sat,
  output logic             o_ovf
);

  // state | meaning
  // IDLE  | no partial sum held; next beat starts a result
  // ACC   | r_acc holds a partial sum, r_rem beats still to come
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] Q_MIN = (ACC_W+1)'(-128);

  logic [0:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_rem;
  logic             r_rq_valid;
  logic [ACC_W-1:0] r_sum;
  logic [4:0]       r_shift;
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic             r_sat;
  logic             r_ovf;

  logic [ACC_W-1:0]        w_beat_ext;
  logic [LEN_W-1:0]        w_len_eff;
  logic                    w_final;
  logic [ACC_W-1:0]        w_total;
  logic signed [ACC_W:0]   w_sum_ext;
  logic signed [ACC_W:0]   w_rnd;
  logic signed [ACC_W:0]   w_rq;
  logic                    w_sat_hi;
  logic                    w_sat_lo;
  logic [7:0]              w_q;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;

  assign w_beat_ext = {{(ACC_W-19){i_res[18]}}, i_res};
  assign w_len_eff  = (i_len == '0) ? LEN_W'(1) : i_len;
  assign w_final    = i_valid && (((r_state == S_IDLE) && (w_len_eff == LEN_W'(1))) ||
                                  ((r_state == S_ACC)  && (r_rem == LEN_W'(1))));
  assign w_total    = (r_state == S_ACC) ? (r_acc + w_beat_ext) : w_beat_ext;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
    end else if (i_clear) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
    end else if (i_valid) begin
      if (w_final) begin
        r_state <= S_IDLE;
        r_acc   <= '0;
        r_rem   <= '0;
      end else if (r_state == S_IDLE) begin
        r_state <= S_ACC;
        r_acc   <= w_beat_ext;
        r_rem   <= w_len_eff - LEN_W'(1);
      end else begin
        r_acc   <= w_total;
        r_rem   <= r_rem - LEN_W'(1);
      end
    end
  end

  // Requant stage holds a finished sum for exactly one cycle; it is always drained next edge.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_rq_valid <= 1'b0;
      r_sum      <= '0;
      r_shift    <= '0;
    end else if (i_clear) begin
      r_rq_valid <= 1'b0;
    end else begin
      r_rq_valid <= w_final;
      if (w_final) begin
        r_sum   <= w_total;
        r_shift <= i_shift;
      end
    end
  end

  assign w_sum_ext = {r_sum[ACC_W-1], r_sum};
  assign w_rnd     = (r_shift == 5'd0) ? '0 : ((ACC_W+1)'(1) << (r_shift - 5'd1));
  assign w_rq      = (w_sum_ext + w_rnd) >>> r_shift;
  assign w_sat_hi  = (w_rq > Q_MAX);
  assign w_sat_lo  = (w_rq < Q_MIN);
  assign w_q       = w_sat_hi ? 8'h7f : (w_sat_lo ? 8'h80 : w_rq[7:0]);

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_pop   = !w_empty && i_ready;
  assign w_push  = r_rq_valid && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wr_ptr[PW-1:0]] <= w_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_sat    <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_sat    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (r_rq_valid && (w_sat_hi || w_sat_lo)) r_sat <= 1'b1;
      if (r_rq_valid && !w_push) r_ovf <= 1'b1;
    end
  end

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr[PW-1:0]];
  assign o_busy  = (r_state == S_ACC) || r_rq_valid;
  assign o_sat   = r_sat;
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_mac_requant_accum.sv
// Directed bench for mac_requant_accum: a transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_mac_requant_accum;

  logic        i_clk = 1'b0;
  logic        i_nrst = 1'b0;
  logic        i_valid = 1'b0;
  logic [18:0] i_res = '0;
  logic [7:0]  i_len = '0;
  logic [4:0]  i_shift = '0;
  logic        i_clear = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        o_busy;
  logic        o_sat;
  logic        o_ovf;

  int tests = 0;
  int fails = 0;

  mac_requant_accum #(.ACC_W(32), .LEN_W(8), .FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_valid(i_valid), .i_res(i_res),
    .i_len(i_len), .i_shift(i_shift), .i_clear(i_clear),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_busy(o_busy), .o_sat(o_sat), .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: results as whole numbers; the output buffer is a queue of int8 values.
  longint m_sum;
  int     m_left;
  bit     m_pend;
  longint m_pend_sum;
  int     m_pend_sh;
  int     m_q[$];
  bit     m_sat;
  bit     m_ovf;
  int     got[$];

  function automatic longint requant(input longint s, input int sh);
    longint t;
    t = s + ((sh > 0) ? (longint'(1) << (sh - 1)) : 64'sd0);
    return t >>> sh;
  endfunction

  always @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      m_sum = 0; m_left = 0; m_pend = 0; m_q.delete(); m_sat = 0; m_ovf = 0;
    end else if (i_clear) begin
      m_sum = 0; m_left = 0; m_pend = 0; m_q.delete(); m_sat = 0; m_ovf = 0;
    end else begin
      bit pop;
      bit was_full;
      longint r;
      int q;
      pop = (m_q.size() > 0) && i_ready;
      was_full = (m_q.size() == 4);
      if (pop) void'(m_q.pop_front());
      if (m_pend) begin
        r = requant(m_pend_sum, m_pend_sh);
        q = (r > 127) ? 127 : ((r < -128) ? -128 : int'(r));
        if (r > 127 || r < -128) m_sat = 1;
        if (!was_full || pop) m_q.push_back(q);
        else m_ovf = 1;
      end
      m_pend = 0;
      if (i_valid) begin
        if (m_left == 0) begin
          m_sum = longint'($signed(i_res));
          m_left = (i_len == 0) ? 1 : int'(i_len);
        end else begin
          m_sum += longint'($signed(i_res));
        end
        m_left--;
        if (m_left == 0) begin
          m_pend = 1; m_pend_sum = m_sum; m_pend_sh = int'(i_shift);
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (!i_nrst) begin
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_busy", o_busy, 0);
    end else begin
      chk("m_valid", o_valid, m_q.size() > 0);
      if (m_q.size() > 0) chk("m_data", longint'($signed(o_data)), m_q[0]);
      chk("m_busy", o_busy, (m_left != 0) || m_pend);
      chk("m_sat", o_sat, m_sat);
      chk("m_ovf", o_ovf, m_ovf);
      if (o_valid && i_ready) got.push_back(int'($signed(o_data)));
    end
  end

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic beat(input int res, input int len, input int sh);
    logic [31:0] v;
    v = res;
    i_valid = 1'b1; i_res = v[18:0]; i_len = 8'(len); i_shift = 5'(sh);
    step();
    i_valid = 1'b0;
  endtask

  task automatic pop_chk(input string name, input int exp);
    int n;
    n = 0;
    while (!o_valid && n < 10) begin step(); n++; end
    chk({name, "_avail"}, o_valid, 1);
    chk(name, longint'($signed(o_data)), exp);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
  endtask

  task automatic chk_got(input string name, input int exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("reset_valid", o_valid, 0);
    chk("reset_sat", o_sat, 0);
    chk("reset_ovf", o_ovf, 0);
    repeat (2) @(posedge i_clk);
    #2 i_nrst = 1'b1;
    step();

    // Basic: 10 - 3 + 7 + 1 = 15
    beat(10, 4, 0); beat(-3, 4, 0); beat(7, 4, 0); beat(1, 4, 0);
    step();
    chk("basic_valid", o_valid, 1);
    chk("basic_data", longint'($signed(o_data)), 15);
    i_ready = 1'b1; step(); i_ready = 1'b0;
    chk("basic_empty", o_valid, 0);

    // Rounding and saturation
    beat(6, 1, 2); beat(-6, 1, 2); beat(5000, 1, 4); beat(-262144, 1, 8);
    step(); step();
    pop_chk("rnd_pos", 2);
    pop_chk("rnd_neg", -1);
    pop_chk("sat_hi", 127);
    pop_chk("sat_lo", -128);
    chk("sat_flag", o_sat, 1);

    // Back-to-back pairs
    got.delete();
    i_ready = 1'b1;
    for (int k = 1; k <= 6; k++) beat(k, 2, 0);
    repeat (4) step();
    i_ready = 1'b0;
    chk_got("b2b", '{3, 7, 11});

    // Overflow: six results into four entries
    for (int k = 1; k <= 6; k++) beat(k, 1, 0);
    repeat (3) step();
    chk("ovf_flag", o_ovf, 1);
    for (int k = 1; k <= 4; k++) pop_chk("ovf_pop", k);
    chk("ovf_empty", o_valid, 0);

    // Full FIFO with a pop on the write cycle: no drop
    i_clear = 1'b1; step(); i_clear = 1'b0;
    chk("clr_ovf", o_ovf, 0);
    for (int k = 1; k <= 4; k++) beat(k, 1, 0);
    repeat (3) step();
    beat(5, 1, 0);
    i_ready = 1'b1; step(); i_ready = 1'b0;
    step();
    chk("nodrop_ovf", o_ovf, 0);
    for (int k = 2; k <= 5; k++) pop_chk("nodrop_pop", k);
    chk("nodrop_empty", o_valid, 0);

    // Clear mid-accumulation, with a pending saturated entry
    beat(5000, 1, 4); step(); step();
    chk("pre_clr_sat", o_sat, 1);
    beat(100, 8, 0); beat(100, 8, 0); beat(100, 8, 0);
    i_clear = 1'b1; i_valid = 1'b1; i_res = 19'd100; i_len = 8'd8;
    step();
    i_clear = 1'b0; i_valid = 1'b0;
    chk("clr_valid", o_valid, 0);
    chk("clr_sat", o_sat, 0);
    chk("clr_ovf2", o_ovf, 0);
    chk("clr_busy", o_busy, 0);
    beat(9, 1, 0);
    pop_chk("after_clr", 9);

    // Async reset mid-accumulation with an entry buffered
    beat(7, 1, 0); step(); step();
    beat(50, 4, 0); beat(50, 4, 0);
    #1 i_nrst = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_data", o_data, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_sat", o_sat, 0);
    chk("arst_ovf", o_ovf, 0);
    step(); step();
    i_nrst = 1'b1;
    step();
    beat(4, 2, 0); beat(4, 2, 0);
    pop_chk("after_rst", 8);
    step();
    chk("final_empty", o_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_requant_accum.md
# mac_requant_accum

Downstream stage of the 8-lane int8 MAC. It consumes the MAC's 19-bit signed dot-product stream and accumulates a programmable number of consecutive partial sums into one result. Each finished sum is requantized to int8 with a rounding arithmetic right shift and saturation. Results are buffered in a small FIFO with a valid/ready interface. The MAC cannot stall, so this block never back-pressures its input; it drops a result and flags it when the buffer is full.

## Interface
- `ACC_W`, default 32: accumulator width. Must satisfy ACC_W ≥ 19 + LEN_W.
- `LEN_W`, default 8: width of the term-count input.
- `FIFO_DEPTH`, default 4: number of output buffer entries; power of two, ≥ 2.

Ports:
- `i_clk`, in, 1: clock, rising edge.
- `i_nrst`, in, 1: asynchronous, active-low reset.
- `i_valid`, in, 1: `i_res` carries a beat this cycle. The integrator aligns it to the MAC's 3-cycle latency.
- `i_res`, in, 19: signed partial dot product.
- `i_len`, in, LEN_W: terms per result. Sampled on the first beat of each result. 0 is treated as 1.
- `i_shift`, in, 5: right-shift amount. Sampled on the final beat of each result.
- `i_clear`, in, 1: synchronous abort and flush.
- `o_valid`, out, 1: FIFO not empty.
- `o_data`, out, 8: signed int8 at the FIFO head (first-word fall-through).
- `i_ready`, in, 1: consumer accepts `o_data`. A pop happens when `o_valid && i_ready`.
- `o_busy`, out, 1: an accumulation is in progress, or the requant stage holds a result.
- `o_sat`, out, 1: sticky; some result saturated.
- `o_ovf`, out, 1: sticky; some result was dropped because the FIFO was full.

## Operation
- **State machine.** Two states, IDLE and ACC.
  - IDLE, beat arrives with effective length L = 1: this is the final beat; stay in IDLE.
  - IDLE, beat arrives with L > 1: acc ← sext(i_res), remaining ← L−1, go to ACC.
  - ACC, each beat: remaining decrements; acc ← acc + sext(i_res).
  - ACC, beat with remaining = 1: this is the final beat; go to IDLE.
  - No beat: hold state and all registers.
- **Final beat.** The complete sum (acc + i_res, or i_res alone when L = 1) is registered into the requant stage, together with i_shift, and the stage is marked valid.
- **Back-to-back results.** A beat in the cycle after a final beat starts a new result. No bubble is required.
- **Requant stage.** Computed combinationally from the registered sum s:
  - r = (s + (shift > 0 ? 2^(shift−1) : 0)) >>> shift, computed in ACC_W+1 bits (round half up).
  - If r > 127, output 127; if r < −128, output −128. Either case sets `o_sat`.
  - Shifts larger than ACC_W give 0 or −1 per the sign of s, then the rounding above applies.
- **FIFO write.** The requant result is written the cycle after it is registered.
  - If the FIFO is full and no pop happens that cycle, the result is discarded and `o_ovf` is set.
  - If the FIFO is full and a pop happens the same cycle, the write succeeds.
- **Accumulator width.** Inputs are sign-extended. Accumulation never wraps for legal parameters.
- **`i_clear`.** Has priority over everything in the same cycle.
  - Returns the state to IDLE and zeroes acc and remaining.
  - Invalidates the requant stage and empties the FIFO.
  - Clears `o_sat` and `o_ovf`.
  - Ignores any `i_valid` beat in the same cycle.
- **Reset.** Asynchronous assertion. All outputs are 0 during reset: `o_valid`, `o_data`, `o_busy`, `o_sat`, `o_ovf`. State is IDLE and the FIFO is empty. Reset mid-accumulation loses the partial sum.

## Timing
- Let the final beat be sampled at edge E.
  - The sum is registered at E.
  - The FIFO is written at E+1.
  - `o_valid` rises after E+1, i.e. 2 cycles after the final beat when the FIFO was empty.
- Pop: the head advances at the edge where `o_valid && i_ready`. The next entry, if any, is visible the following cycle.
- Simultaneous push and pop: count unchanged, order preserved.
- Throughput:
  - One input beat per cycle, always; `i_valid` is never stalled.
  - Output sustains one result per cycle when L = 1 and `i_ready` = 1.
- `o_busy` is high from the cycle after the first beat until the cycle after the requant stage empties.
- `o_sat` and `o_ovf` rise the cycle after the causing FIFO-write edge.

## Test plan
- **Basic:** L = 4, shift = 0; beats 10, −3, 7, 1 → after 2 cycles `o_data` = 15 and `o_valid` = 1; pop with `i_ready` → `o_valid` = 0.
- **Rounding and saturation:**
  - L = 1, shift = 2, beat 6 → 2.
  - beat −6 → −1.
  - beat 5000, shift 4 → 127, `o_sat` = 1.
  - beat −262144, shift 8 → −128.
- **Back-to-back:** L = 2; continuous beats 1, 2, 3, 4, 5, 6 with `i_ready` = 1 → outputs 3, 7, 11 on consecutive-result cadence, with no lost beat.
- **Overflow:** `i_ready` = 0, L = 1, 6 consecutive beats 1..6 → FIFO holds 1, 2, 3, 4; `o_ovf` = 1. Then pop 4 times → 1, 2, 3, 4, then `o_valid` = 0.
  - Repeat with FIFO full and `i_ready` = 1 on the write cycle → no drop.
- **Clear mid-operation:** L = 8, 3 beats of 100, then `i_clear` together with `i_valid` → next L = 1 beat of 9 outputs 9, not 309. FIFO, `o_sat` and `o_ovf` read 0 after clear.
- **Async reset:** drop `i_nrst` mid-accumulation, between clock edges → all outputs go to 0 immediately. After release, L = 2 beats 4, 4 → output 8.
